// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: synchronizes release of rst, then releases per-stage resets in index order,
// waiting on each stage's ready with a timeout. Define RST_SEQ_ASSERT_EN for embedded assertions.
module rst_seq_ctrl #(
  parameter int unsigned NUM_STAGES  = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned RELEASE_GAP = 4,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sw_rst_req,
  input  logic [NUM_STAGES-1:0] stage_ready,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  busy,
  output logic                  seq_done,
  output logic                  timeout_err,
  output logic [(NUM_STAGES > 1 ? $clog2(NUM_STAGES) : 1)-1:0] err_stage
);

  localparam int unsigned IdxW   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int unsigned MaxHG  = (HOLD_CYCLES > RELEASE_GAP) ? HOLD_CYCLES : RELEASE_GAP;
  localparam int unsigned MaxCnt = (MaxHG > TIMEOUT) ? MaxHG : TIMEOUT;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  typedef enum logic [2:0] {StHold, StRelease, StWaitRdy, StDone, StError} state_e;

  state_e                 state;
  logic [CntW-1:0]        cnt;
  logic [IdxW-1:0]        idx;
  logic [SYNC_STAGES-1:0] sync;
  logic                   frozen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign frozen = sync[SYNC_STAGES-1];

  // Released stages always form a contiguous low run, so releasing the next stage is a left shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StHold;
      cnt         <= '0;
      idx         <= '0;
      rst_out     <= '1;
      busy        <= 1'b1;
      seq_done    <= 1'b0;
      timeout_err <= 1'b0;
      err_stage   <= '0;
    end else if (!frozen) begin
      if (sw_rst_req) begin
        state       <= StHold;
        cnt         <= '0;
        idx         <= '0;
        rst_out     <= '1;
        busy        <= 1'b1;
        seq_done    <= 1'b0;
        timeout_err <= 1'b0;
      end else begin
        unique case (state)
          StHold: begin
            if (cnt == CntW'(HOLD_CYCLES - 1)) begin
              state   <= StRelease;
              cnt     <= '0;
              idx     <= '0;
              rst_out <= rst_out << 1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          StRelease: begin
            if (cnt == CntW'(RELEASE_GAP - 1)) begin
              state <= StWaitRdy;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          StWaitRdy: begin
            if (stage_ready[idx]) begin
              if (idx == IdxW'(NUM_STAGES - 1)) begin
                state    <= StDone;
                rst_out  <= '0;
                busy     <= 1'b0;
                seq_done <= 1'b1;
              end else begin
                state   <= StRelease;
                cnt     <= '0;
                idx     <= idx + 1'b1;
                rst_out <= rst_out << 1;
              end
            end else if (cnt == CntW'(TIMEOUT - 1)) begin
              state       <= StError;
              rst_out     <= '1;
              busy        <= 1'b0;
              timeout_err <= 1'b1;
              err_stage   <= idx;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          StDone, StError: begin
          end
          default: state <= StHold;
        endcase
      end
    end
  end

`ifdef RST_SEQ_ASSERT_EN
  logic [NUM_STAGES-1:0] rel_mask;
  assign rel_mask = ~rst_out;

  a_order: assert property (@(posedge clk) disable iff (rst)
      ((rel_mask & (rel_mask + 1'b1)) == '0))
    else $error("rst_out release order violated: %b", rst_out);
  a_done_ready: assert property (@(posedge clk) disable iff (rst) seq_done |-> (&stage_ready))
    else $error("seq_done with stage_ready=%b", stage_ready);
  a_one_fall: assert property (@(posedge clk) disable iff (rst)
      ($countones($past(rst_out) & ~rst_out) <= 1))
    else $error("more than one rst_out bit fell in one cycle");
  a_excl: assert property (@(posedge clk) disable iff (rst) !(seq_done && timeout_err))
    else $error("seq_done and timeout_err both high");
  a_busy: assert property (@(posedge clk) disable iff (rst) busy == !(seq_done || timeout_err))
    else $error("busy inconsistent with seq_done/timeout_err");
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl: expected outputs come from release/timeout edge times
// computed directly from the sequencing rules.
module tb_rst_seq_ctrl;
  localparam int N = 4, S = 2, H = 8, GAP = 4, TO = 64, NEVER = 1 << 30;
  localparam logic [8:0] RstV = 9'b1111_100_00;

  logic       clk = 1'b0, rst = 1'b0, sw_rst_req = 1'b0;
  logic [3:0] stage_ready = '0;
  logic [3:0] rst_out;
  logic       busy, seq_done, timeout_err;
  logic [1:0] err_stage;

  int checks = 0, errors = 0;
  int e, err_e, err_k, done_e;
  int rel[N], thr[N], w[N];
  logic [1:0] es_hold;
  logic [8:0] obs, exp_v;

  rst_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .sw_rst_req (sw_rst_req),
    .stage_ready(stage_ready),
    .rst_out    (rst_out),
    .busy       (busy),
    .seq_done   (seq_done),
    .timeout_err(timeout_err),
    .err_stage  (err_stage)
  );

  always #5 clk = ~clk;

  assign obs = {rst_out, busy, seq_done, timeout_err, err_stage};

  // Expected outputs after edge ee of the current plan.
  function automatic logic [8:0] exp_out(input int ee);
    logic [3:0] r;
    if (ee >= err_e) return {4'hF, 3'b001, 2'(err_k)};
    if (ee >= done_e) return {4'h0, 3'b010, es_hold};
    for (int k = 0; k < N; k++) r[k] = (ee < rel[k]);
    return {r, 3'b100, es_hold};
  endfunction

  // w[k] = number of zero ready samples before stage k reports ready (>= TO: never).
  task automatic plan(input int base);
    int  r;
    bit  stop;
    if (e >= err_e) es_hold = 2'(err_k);
    err_e = NEVER; done_e = NEVER; stop = 0; r = base + H;
    for (int k = 0; k < N; k++) begin rel[k] = NEVER; thr[k] = NEVER; end
    for (int k = 0; k < N; k++) begin
      if (!stop) begin
        rel[k] = r;
        if (w[k] >= TO) begin
          err_e = r + GAP + TO; err_k = k; stop = 1;
        end else begin
          r = r + GAP + 1 + w[k]; thr[k] = r;
          if (k == N - 1) done_e = r;
        end
      end
    end
  endtask

  task automatic step();
    for (int k = 0; k < N; k++) stage_ready[k] = (e + 1 >= thr[k]);
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1; sw_rst_req = 1'b0; stage_ready = '0;
    for (int k = 0; k < N; k++) thr[k] = NEVER;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; e = 0; err_e = NEVER; done_e = NEVER; es_hold = '0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs !== RstV) begin
      errors++; $display("FAIL reset_async got=%b expected=%b", obs, RstV);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (obs !== RstV) begin
        errors++; $display("FAIL reset_hold cyc=%0d got=%b expected=%b", i, obs, RstV);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_power_up();
    do_reset();
    w = '{0, 0, 0, 0};
    plan(S);
    for (int k = 0; k < N; k++) thr[k] = 0;
    repeat (40) begin
      step();
      exp_v = exp_out(e); checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL power_up e=%0d got=%b expected=%b", e, obs, exp_v);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    w = '{0, 0, TO, 0};
    plan(S);
    repeat (95) begin
      step();
      exp_v = exp_out(e); checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL timeout e=%0d got=%b expected=%b", e, obs, exp_v);
      end
    end
    w = '{0, 0, 0, 0};
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    plan(e);
    for (int k = 0; k < N; k++) thr[k] = 0;
    exp_v = exp_out(e); checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL timeout_sw e=%0d got=%b expected=%b", e, obs, exp_v);
    end
    repeat (40) begin
      step();
      exp_v = exp_out(e); checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL timeout_rerun e=%0d got=%b expected=%b", e, obs, exp_v);
      end
    end
  endtask

  // Continues from the completed sequence left by test_timeout.
  task automatic test_sw_in_done();
    w = '{0, 0, 0, 0};
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    plan(e);
    for (int k = 0; k < N; k++) thr[k] = 0;
    exp_v = exp_out(e); checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL sw_done_entry e=%0d got=%b expected=%b", e, obs, exp_v);
    end
    repeat (40) begin
      step();
      exp_v = exp_out(e); checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL sw_done_rerun e=%0d got=%b expected=%b", e, obs, exp_v);
      end
    end
  endtask

  task automatic test_async_rst();
    do_reset();
    w = '{0, 30, 0, 0};
    plan(S);
    repeat (25) begin
      step();
      exp_v = exp_out(e); checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL async_pre e=%0d got=%b expected=%b", e, obs, exp_v);
      end
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs !== RstV) begin
      errors++; $display("FAIL async_rst got=%b expected=%b", obs, RstV);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; e = 0; err_e = NEVER; done_e = NEVER; es_hold = '0;
    w = '{0, 0, 0, 0};
    plan(S);
    for (int k = 0; k < N; k++) thr[k] = 0;
    repeat (35) begin
      step();
      exp_v = exp_out(e); checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL async_restart e=%0d got=%b expected=%b", e, obs, exp_v);
      end
    end
  endtask

  // Stage 1 ready arrives on its 10th sample (edge 29) together with sw_rst_req.
  task automatic test_sw_priority();
    do_reset();
    w = '{0, 9, 0, 0};
    plan(S);
    while (e < 28) begin
      step();
      exp_v = exp_out(e); checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL sw_prio_pre e=%0d got=%b expected=%b", e, obs, exp_v);
      end
    end
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    w = '{0, 0, 0, 0};
    plan(e);
    repeat (13) begin
      exp_v = exp_out(e); checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL sw_prio e=%0d got=%b expected=%b", e, obs, exp_v);
      end
      step();
    end
  endtask

  task automatic test_random();
    int end_e, sw_at;
    for (int it = 0; it < 8; it++) begin
      do_reset();
      for (int k = 0; k < N; k++)
        w[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO + 5))
                                           : int'($urandom_range(0, 6));
      plan(S);
      end_e = (err_e < done_e) ? err_e : done_e;
      sw_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(3, end_e)) : NEVER;
      while (e < end_e + 3) begin
        if (e + 1 == sw_at) begin
          sw_rst_req = 1'b1;
          step();
          sw_rst_req = 1'b0;
          for (int k = 0; k < N; k++) w[k] = int'($urandom_range(0, TO + 2));
          plan(e);
          end_e = (err_e < done_e) ? err_e : done_e;
          sw_at = NEVER;
        end else begin
          step();
        end
        exp_v = exp_out(e); checks++;
        if (obs !== exp_v) begin
          errors++; $display("FAIL random it=%0d e=%0d got=%b expected=%b", it, e, obs, exp_v);
        end
      end
    end
  endtask

  initial begin
    e = 0; err_e = NEVER; done_e = NEVER; err_k = 0; es_hold = '0;
    for (int k = 0; k < N; k++) begin rel[k] = NEVER; thr[k] = NEVER; w[k] = 0; end
    test_reset();
    test_power_up();
    test_timeout();
    test_sw_in_done();
    test_async_rst();
    test_sw_priority();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
